// File: rtl/xdispscan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Includes register addresses, scan states, reset constants and the hex-to-segment table.
package xdispscan_pkg;

   localparam logic [2:0] DS_DIG0 = 3'd0;
   localparam logic [2:0] DS_DIG1 = 3'd1;
   localparam logic [2:0] DS_DIG2 = 3'd2;
   localparam logic [2:0] DS_DIG3 = 3'd3;
   localparam logic [2:0] DS_CTRL = 3'd4;
   localparam logic [2:0] DS_STAT = 3'd5;

   localparam logic [7:0]  DS_BLANK_DIGIT = 8'h10;
   localparam logic [11:0] DS_PINS_DARK   = 12'hFFF;

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_ON  = 2'd1,
      ST_GAP = 2'd2
   } scan_state_e;

   // The segment code is active-low, with segment a in bit 0 and segment g in bit 6.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/xdispscan_if.sv
// Peripheral data-bus port of the display scan controller.
interface xdispscan_if;
   logic       sel;
   logic       we;
   logic [2:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (output sel, we, addr, data_in, input data_out);
   modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xdispscan_xseg7dec.sv
// Converts {blank, dp, hex} to an active-low 7-segment code; bit 7 drives the decimal point.
module xseg7dec
   import xdispscan_pkg::*;
(
   input  logic       blank,
   input  logic       dp,
   input  logic [3:0] hex,
   output logic [7:0] seg
);

   // The decimal point is decoded independently of blank, so a blanked digit can still light its dp.
   assign seg = {~dp, blank ? 7'h7F : hex_to_seg(hex)};

endmodule

// File: rtl/xdispscan.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered digit registers.
// Staged digits are committed only at frame boundaries, so a value is never shown half-updated.
module xdispscan
   import xdispscan_pkg::*;
#(
   parameter int DIV  = 50000,
   parameter int DEAD = 500
) (
   input  logic         clk,
   input  logic         rst,
   xdispscan_if.slave   bus,
   output logic [11:0]  disp_ctrl
);

   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DEAD_W = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
   localparam int CNT_W  = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);

   logic [5:0]       stage_q [4];
   logic [5:0]       stage_d [4];
   logic [5:0]       active_q [4];
   logic [5:0]       active_d [4];
   logic             en_q, en_d;
   scan_state_e      st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [11:0]      pins_q, pins_d;
   logic             commit;
   logic [7:0]       seg;
   logic             unused_bits;

   assign unused_bits = ^bus.data_in[7:6];

   always_comb begin
      en_d = en_q;
      for (int i = 0; i < 4; i++) stage_d[i] = stage_q[i];
      if (bus.sel && bus.we) begin
         if (bus.addr == DS_CTRL)
            en_d = bus.data_in[0];
         else if (!bus.addr[2])
            stage_d[bus.addr[1:0]] = bus.data_in[5:0];
      end
   end

   // The next state uses the post-write enable, so an enable write takes effect on the very next edge.
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      commit = (st_q == ST_OFF);
      if (!en_d) begin
         st_d  = ST_OFF;
         cnt_d = '0;
         idx_d = '0;
      end else begin
         case (st_q)
            ST_OFF: begin
               st_d  = ST_ON;
               cnt_d = '0;
               idx_d = '0;
            end
            ST_ON: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_d = '0;
                  if (DEAD == 0) begin
                     idx_d  = idx_q + 2'd1;
                     commit = (idx_q == 2'd3);
                  end else begin
                     st_d = ST_GAP;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d  = '0;
                  idx_d  = idx_q + 2'd1;
                  st_d   = ST_ON;
                  commit = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               st_d  = ST_OFF;
               cnt_d = '0;
               idx_d = '0;
            end
         endcase
      end
   end

   // A commit copies the pre-write staging contents; a write in the same cycle waits for the next frame.
   always_comb begin
      for (int i = 0; i < 4; i++) active_d[i] = commit ? stage_q[i] : active_q[i];
   end

   xseg7dec u_dec (
      .blank (active_q[idx_q][4]),
      .dp    (active_q[idx_q][5]),
      .hex   (active_q[idx_q][3:0]),
      .seg   (seg)
   );

   always_comb begin
      pins_d = DS_PINS_DARK;
      if (st_q == ST_ON) pins_d = {~(4'b0001 << idx_q), seg};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            stage_q[i]  <= DS_BLANK_DIGIT[5:0];
            active_q[i] <= DS_BLANK_DIGIT[5:0];
         end
         en_q   <= 1'b0;
         st_q   <= ST_OFF;
         cnt_q  <= '0;
         idx_q  <= '0;
         pins_q <= DS_PINS_DARK;
      end else begin
         stage_q  <= stage_d;
         active_q <= active_d;
         en_q     <= en_d;
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         pins_q   <= pins_d;
      end
   end

   assign disp_ctrl = pins_q;

   always_comb begin
      case (bus.addr)
         DS_DIG0, DS_DIG1, DS_DIG2, DS_DIG3: bus.data_out = {2'b00, stage_q[bus.addr[1:0]]};
         DS_CTRL: bus.data_out = {7'b0, en_q};
         DS_STAT: bus.data_out = {4'b0, en_q, st_q == ST_GAP, idx_q};
         default: bus.data_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_xdispscan.sv
// Directed bench for xdispscan: one DUT with DIV=4/DEAD=1 and one DUT with DIV=4/DEAD=0.
// Pin expectations are hand-computed digit codes placed on a known frame timeline.
module tb_xdispscan;

   localparam logic [11:0] DARK   = 12'hFFF;
   localparam logic [11:0] D0_5DP = 12'hE12;
   localparam logic [11:0] D0_0   = 12'hEC0;
   localparam logic [11:0] D0_8   = 12'hE80;
   localparam logic [11:0] D1_1   = 12'hDF9;
   localparam logic [11:0] D2_BL  = 12'hBFF;
   localparam logic [11:0] D3_A   = 12'h788;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] pins_a, pins_b;
   int          checks = 0;
   int          failures = 0;

   xdispscan_if bus_a ();
   xdispscan_if bus_b ();

   xdispscan #(.DIV(4), .DEAD(1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_a),
      .disp_ctrl (pins_a)
   );

   xdispscan #(.DIV(4), .DEAD(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_b),
      .disp_ctrl (pins_b)
   );

   always #5 clk = ~clk;

   // p counts negedges after the edge that latched en=1; each digit slot is 4 lit cycles plus the dead cycles.
   function automatic logic [11:0] exp_pin(input int p, input int dead,
                                           input logic [11:0] c0, input logic [11:0] c1,
                                           input logic [11:0] c2, input logic [11:0] c3);
      int slot;
      int q;
      slot = 4 + dead;
      q = (p - 1) % (4 * slot);
      if (p < 1 || (q % slot) >= 4) return DARK;
      case (q / slot)
         0: return c0;
         1: return c1;
         2: return c2;
         default: return c3;
      endcase
   endfunction

   task automatic bus_write(input bit b0, input logic [2:0] a, input logic [7:0] d);
      if (b0) begin
         bus_b.sel = 1'b1; bus_b.we = 1'b1; bus_b.addr = a; bus_b.data_in = d;
      end else begin
         bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = a; bus_a.data_in = d;
      end
      @(negedge clk);
      bus_a.sel = 1'b0; bus_a.we = 1'b0;
      bus_b.sel = 1'b0; bus_b.we = 1'b0;
   endtask

   task automatic load_digits(input bit b0, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
      bus_write(b0, 3'd4, 8'h00);
      bus_write(b0, 3'd0, d0);
      bus_write(b0, 3'd1, d1);
      bus_write(b0, 3'd2, d2);
      bus_write(b0, 3'd3, d3);
   endtask

   task automatic test_reset;
      logic [7:0] expv;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (pins_a !== DARK) begin
         failures++;
         $display("[TB] FAIL reset_pins got=%h exp=%h", pins_a, DARK);
      end
      checks++;
      if (pins_b !== DARK) begin
         failures++;
         $display("[TB] FAIL reset_pins_dead0 got=%h exp=%h", pins_b, DARK);
      end
      for (int i = 0; i < 6; i++) begin
         bus_a.addr = 3'(i);
         expv = (i < 4) ? 8'h10 : 8'h00;
         #1;
         checks++;
         if (bus_a.data_out !== expv) begin
            failures++;
            $display("[TB] FAIL reset_read addr=%0d got=%h exp=%h", i, bus_a.data_out, expv);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_scan;
      logic [11:0] e;
      load_digits(1'b0, 8'h25, 8'h01, 8'h10, 8'h0A);
      bus_write(1'b0, 3'd4, 8'h01);
      bus_a.addr = 3'd5;
      checks++;
      if (pins_a !== DARK) begin
         failures++;
         $display("[TB] FAIL basic_first_cycle got=%h exp=%h", pins_a, DARK);
      end
      for (int p = 1; p <= 40; p++) begin
         @(negedge clk);
         e = exp_pin(p, 1, D0_5DP, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_a !== e) begin
            failures++;
            $display("[TB] FAIL basic_scan p=%0d got=%h exp=%h", p, pins_a, e);
         end
         if (p == 4) begin
            checks++;
            if (bus_a.data_out !== 8'h0C) begin
               failures++;
               $display("[TB] FAIL status_gap got=%h exp=0c", bus_a.data_out);
            end
         end
         if (p == 6) begin
            checks++;
            if (bus_a.data_out !== 8'h09) begin
               failures++;
               $display("[TB] FAIL status_on got=%h exp=09", bus_a.data_out);
            end
         end
      end
   endtask

   task automatic test_tear_free;
      logic [11:0] e;
      load_digits(1'b0, 8'h00, 8'h01, 8'h10, 8'h0A);
      bus_write(1'b0, 3'd4, 8'h01);
      for (int p = 1; p <= 44; p++) begin
         @(negedge clk);
         e = exp_pin(p, 1, (p <= 20) ? D0_0 : D0_8, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_a !== e) begin
            failures++;
            $display("[TB] FAIL tear_free p=%0d got=%h exp=%h", p, pins_a, e);
         end
         if (p == 7) begin
            bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = 3'd0; bus_a.data_in = 8'h08;
         end
         if (p == 8) begin
            bus_a.sel = 1'b0; bus_a.we = 1'b0;
         end
      end
   endtask

   task automatic test_commit_collision;
      logic [11:0] e;
      load_digits(1'b0, 8'h00, 8'h01, 8'h10, 8'h0A);
      bus_write(1'b0, 3'd4, 8'h01);
      for (int p = 1; p <= 44; p++) begin
         @(negedge clk);
         e = exp_pin(p, 1, (p <= 40) ? D0_0 : D0_8, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_a !== e) begin
            failures++;
            $display("[TB] FAIL commit_collision p=%0d got=%h exp=%h", p, pins_a, e);
         end
         if (p == 19) begin
            bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = 3'd0; bus_a.data_in = 8'h08;
         end
         if (p == 20) begin
            bus_a.sel = 1'b0; bus_a.we = 1'b0;
         end
      end
   endtask

   task automatic test_mid_disable;
      logic [11:0] e;
      load_digits(1'b0, 8'h25, 8'h01, 8'h10, 8'h0A);
      bus_write(1'b0, 3'd4, 8'h01);
      for (int p = 1; p <= 13; p++) begin
         @(negedge clk);
         e = exp_pin(p, 1, D0_5DP, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_a !== e) begin
            failures++;
            $display("[TB] FAIL disable_run p=%0d got=%h exp=%h", p, pins_a, e);
         end
         if (p == 12) begin
            bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = 3'd4; bus_a.data_in = 8'h00;
         end
         if (p == 13) begin
            bus_a.sel = 1'b0; bus_a.we = 1'b0;
         end
      end
      for (int p = 14; p <= 15; p++) begin
         @(negedge clk);
         checks++;
         if (pins_a !== DARK) begin
            failures++;
            $display("[TB] FAIL disable_dark p=%0d got=%h exp=%h", p, pins_a, DARK);
         end
      end
      bus_a.addr = 3'd5;
      #1;
      checks++;
      if (bus_a.data_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL disable_status got=%h exp=00", bus_a.data_out);
      end
      bus_write(1'b0, 3'd4, 8'h01);
      for (int p = 1; p <= 6; p++) begin
         @(negedge clk);
         e = exp_pin(p, 1, D0_5DP, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_a !== e) begin
            failures++;
            $display("[TB] FAIL reenable p=%0d got=%h exp=%h", p, pins_a, e);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [11:0] e;
      load_digits(1'b0, 8'h25, 8'h01, 8'h10, 8'h0A);
      bus_write(1'b0, 3'd4, 8'h01);
      for (int p = 1; p <= 7; p++) begin
         @(negedge clk);
         e = exp_pin(p, 1, D0_5DP, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_a !== e) begin
            failures++;
            $display("[TB] FAIL pre_reset p=%0d got=%h exp=%h", p, pins_a, e);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (pins_a !== DARK) begin
         failures++;
         $display("[TB] FAIL async_reset_pins got=%h exp=%h", pins_a, DARK);
      end
      for (int i = 0; i < 6; i++) begin
         bus_a.addr = 3'(i);
         #1;
         checks++;
         if (bus_a.data_out !== ((i < 4) ? 8'h10 : 8'h00)) begin
            failures++;
            $display("[TB] FAIL mid_reset_read addr=%0d got=%h exp=%h", i, bus_a.data_out,
                     (i < 4) ? 8'h10 : 8'h00);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_dead0_readback;
      logic [11:0] e;
      logic [7:0]  s;
      load_digits(1'b1, 8'h25, 8'h01, 8'h10, 8'h0A);
      bus_write(1'b1, 3'd4, 8'h01);
      bus_b.addr = 3'd5;
      for (int p = 1; p <= 32; p++) begin
         @(negedge clk);
         e = exp_pin(p, 0, D0_5DP, D1_1, D2_BL, D3_A);
         checks++;
         if (pins_b !== e) begin
            failures++;
            $display("[TB] FAIL dead0_scan p=%0d got=%h exp=%h", p, pins_b, e);
         end
         s = 8'h08 | 8'((p / 4) % 4);
         checks++;
         if (bus_b.data_out !== s) begin
            failures++;
            $display("[TB] FAIL dead0_status p=%0d got=%h exp=%h", p, bus_b.data_out, s);
         end
      end
      bus_write(1'b1, 3'd6, 8'hFF);
      bus_b.addr = 3'd6;
      #1;
      checks++;
      if (bus_b.data_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL addr6_read got=%h exp=00", bus_b.data_out);
      end
      bus_write(1'b1, 3'd0, 8'hFF);
      bus_b.addr = 3'd0;
      #1;
      checks++;
      if (bus_b.data_out !== 8'h3F) begin
         failures++;
         $display("[TB] FAIL digit_upper_bits got=%h exp=3f", bus_b.data_out);
      end
      bus_write(1'b1, 3'd4, 8'hFF);
      bus_b.addr = 3'd4;
      #1;
      checks++;
      if (bus_b.data_out !== 8'h01) begin
         failures++;
         $display("[TB] FAIL ctrl_upper_bits got=%h exp=01", bus_b.data_out);
      end
   endtask

   initial begin
      bus_a.sel = 1'b0; bus_a.we = 1'b0; bus_a.addr = 3'd0; bus_a.data_in = 8'h00;
      bus_b.sel = 1'b0; bus_b.we = 1'b0; bus_b.addr = 3'd0; bus_b.data_in = 8'h00;
      rst = 1'b1;
      test_reset();
      test_basic_scan();
      test_tear_free();
      test_commit_collision();
      test_mid_disable();
      test_reset_mid();
      test_dead0_readback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
